// File: rtl/mem_pkg.sv
// Shared definitions for the memory manager and its initiators.
// Contents: access size codes, splitter state encoding, size_to_bytes helper.
package mem_pkg;

    // Access size codes, shared with the memory manager
    localparam logic [2:0] MEM_B = 3'd0;
    localparam logic [2:0] MEM_H = 3'd1;
    localparam logic [2:0] MEM_W = 3'd2;
    localparam logic [2:0] MEM_D = 3'd3;
    localparam logic [2:0] MEM_Q = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StResp
    } splitter_state_e;

    function automatic int unsigned size_to_bytes(input logic [2:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Sign- or zero-extends the low 2^size bytes of a value to the full width.
// Ports:
//   data        in   WIDTH  value whose low bytes are significant
//   size        in   3      size code (bytes = 2^size)
//   is_unsigned in   1      1 = zero-extend, 0 = sign-extend
//   ext         out  WIDTH  extended value
module load_extender
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       size,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] ext
);

    int   nbits;
    logic sign;

    always_comb begin
        nbits = 8 * int'(size_to_bytes(size));
        sign  = 1'b0;
        ext   = data;
        // Sizes at or above the full width pass through untouched
        if (nbits < int'(WIDTH)) begin
            sign = is_unsigned ? 1'b0 : data[nbits-1];
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (i >= nbits) begin
                    ext[i] = sign;
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_splitter.sv
// Issues pipeline loads/stores to the memory manager's read and write ports.
// Aligned accesses go out as one native-size access; misaligned ones are split
// into single-byte accesses (or faulted when ALLOW_MISALIGNED=0).
// Ports:
//   clk, clr                          clock, synchronous active-high reset
//   req_valid/ready/we/addr/size/     pipeline request (one outstanding)
//   req_unsigned/req_wdata
//   resp_valid/fault/rdata            one-cycle completion
//   mem_wr_addr/data, mem_we,         memory manager write port
//   mem_wr_bytes
//   mem_rd_addr, mem_re, mem_rd_bytes, memory manager read port (1-cycle latency,
//   mem_rd_unsigned, mem_rd_data,     mem_must_wait stalls the read request)
//   mem_must_wait
module mem_access_splitter
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [2:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_fault,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [WIDTH-1:0] mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic             mem_we,
    output logic [2:0]       mem_wr_bytes,
    output logic [WIDTH-1:0] mem_rd_addr,
    output logic             mem_re,
    output logic [2:0]       mem_rd_bytes,
    output logic             mem_rd_unsigned,
    input  logic [WIDTH-1:0] mem_rd_data,
    input  logic             mem_must_wait
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned ALIGN = $clog2(BYTES);
    localparam int unsigned IDX_W = 5;

    splitter_state_e   state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              split_q, split_d;
    logic              fault_q, fault_d;

    logic [WIDTH-1:0]  mask;
    logic              mis;
    logic              bad;
    logic [WIDTH-1:0]  cur_addr;
    logic [WIDTH-1:0]  ext_data;

    assign mask     = (WIDTH'(1) << req_size) - WIDTH'(1);
    assign mis      = |(req_addr & mask);
    assign bad      = 32'(req_size) > ALIGN;
    assign cur_addr = addr_q + WIDTH'(idx_q);

    load_extender #(
        .WIDTH(WIDTH)
    ) u_ext (
        .data       (acc_q),
        .size       (size_q),
        .is_unsigned(uns_q),
        .ext        (ext_data)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        split_d = split_q;
        fault_d = fault_q;

        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        mem_re          = 1'b0;
        mem_we          = 1'b0;
        mem_rd_addr     = cur_addr;
        mem_wr_addr     = cur_addr;
        mem_rd_bytes    = split_q ? MEM_B : size_q;
        mem_wr_bytes    = split_q ? MEM_B : size_q;
        mem_rd_unsigned = split_q | uns_q;
        mem_wr_data     = split_q ? (wdata_q >> {idx_q, 3'b000}) : wdata_q;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    idx_d   = '0;
                    acc_d   = '0;
                    split_d = mis;
                    if (bad || (mis && !ALLOW_MISALIGNED)) begin
                        fault_d = 1'b1;
                        last_d  = '0;
                        state_d = StResp;
                    end else begin
                        fault_d = 1'b0;
                        last_d  = mis ? IDX_W'(size_to_bytes(req_size) - 1) : '0;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (we_q) begin
                    // Writes are always accepted; must_wait only gates reads
                    mem_we = 1'b1;
                    if (idx_q == last_q) begin
                        state_d = StResp;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    mem_re = 1'b1;
                    if (!mem_must_wait) begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (split_q) begin
                    for (int b = 0; b < int'(BYTES); b++) begin
                        if (idx_q == IDX_W'(b)) begin
                            acc_d[8*b +: 8] = mem_rd_data[7:0];
                        end
                    end
                end else begin
                    acc_d = mem_rd_data;
                end
                if (idx_q == last_q) begin
                    state_d = StResp;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StIssue;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset cycle suppresses every strobe immediately
        if (clr) begin
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            resp_valid = 1'b0;
        end
    end

    assign resp_fault = (state_q == StResp) && fault_q;
    assign resp_rdata = ((state_q == StResp) && !we_q && !fault_q) ?
                        (split_q ? ext_data : acc_q) : '0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            split_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            split_q <= split_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_mem_access_splitter.sv
// Directed testbench for mem_access_splitter (WIDTH=32). A second instance with
// ALLOW_MISALIGNED=0 shares all inputs and is observed for fault behaviour.
module tb_mem_access_splitter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [31:0] mem_rd_data = '0;
    logic        mem_must_wait = 1'b0;

    logic        req_ready, resp_valid, resp_fault, mem_we, mem_re, mem_rd_unsigned;
    logic [31:0] resp_rdata, mem_wr_addr, mem_wr_data, mem_rd_addr;
    logic [2:0]  mem_wr_bytes, mem_rd_bytes;

    logic        f_req_ready, f_resp_valid, f_resp_fault, f_mem_we, f_mem_re;
    logic        f_mem_rd_unsigned;
    logic [31:0] f_resp_rdata, f_mem_wr_addr, f_mem_wr_data, f_mem_rd_addr;
    logic [2:0]  f_mem_wr_bytes, f_mem_rd_bytes;

    logic [7:0]  mem [0:4095];

    int errors = 0;
    int checks = 0;

    // Per-transaction observations
    int          resp_cyc, f_resp_cyc, f_strobes;
    logic [31:0] resp_data;
    logic        resp_flt, f_resp_flt;
    logic [31:0] rd_addrs[$], re_all[$], wr_addrs[$], wr_datas[$];
    logic [2:0]  rd_bytes[$], wr_bytes[$];

    always #5 clk = ~clk;

    mem_access_splitter #(.WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_rdata(resp_rdata),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_we(mem_we),
        .mem_wr_bytes(mem_wr_bytes), .mem_rd_addr(mem_rd_addr), .mem_re(mem_re),
        .mem_rd_bytes(mem_rd_bytes), .mem_rd_unsigned(mem_rd_unsigned),
        .mem_rd_data(mem_rd_data), .mem_must_wait(mem_must_wait)
    );

    mem_access_splitter #(.WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_f (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(f_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(f_resp_valid), .resp_fault(f_resp_fault), .resp_rdata(f_resp_rdata),
        .mem_wr_addr(f_mem_wr_addr), .mem_wr_data(f_mem_wr_data), .mem_we(f_mem_we),
        .mem_wr_bytes(f_mem_wr_bytes), .mem_rd_addr(f_mem_rd_addr), .mem_re(f_mem_re),
        .mem_rd_bytes(f_mem_rd_bytes), .mem_rd_unsigned(f_mem_rd_unsigned),
        .mem_rd_data(mem_rd_data), .mem_must_wait(mem_must_wait)
    );

    // Memory manager read model: little-endian bytes, extended per size/unsigned
    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] sz,
                                               input logic u);
        logic [31:0] v;
        logic [11:0] ia;
        int          n;
        v = '0;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                ia = a[11:0] + 12'(i);
                v[8*i +: 8] = mem[ia];
            end
        end
        if (!u && n < 4) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= 8 * n) v[i] = v[8*n-1];
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_re && !mem_must_wait) begin
            mem_rd_data <= model_read(mem_rd_addr, mem_rd_bytes, mem_rd_unsigned);
        end
    end

    // Issue one request, then log strobes cycle by cycle until the response
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                           input logic uns, input logic [31:0] wdata, input int waits);
        int waits_left;
        waits_left = waits;
        resp_cyc = -1; f_resp_cyc = -1; f_strobes = 0;
        resp_data = '0; resp_flt = 1'b0; f_resp_flt = 1'b0;
        rd_addrs.delete(); re_all.delete(); wr_addrs.delete(); wr_datas.delete();
        rd_bytes.delete(); wr_bytes.delete();
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (f_resp_valid && f_resp_cyc < 0) begin
                f_resp_cyc = cyc;
                f_resp_flt = f_resp_fault;
            end
            if (f_mem_re || f_mem_we) f_strobes++;
            if (resp_valid) begin
                resp_cyc  = cyc;
                resp_data = resp_rdata;
                resp_flt  = resp_fault;
                break;
            end
            if (mem_re) begin
                re_all.push_back(mem_rd_addr);
                if (waits_left > 0) begin
                    mem_must_wait = 1'b1;
                    waits_left--;
                end else begin
                    mem_must_wait = 1'b0;
                    rd_addrs.push_back(mem_rd_addr);
                    rd_bytes.push_back(mem_rd_bytes);
                end
            end else begin
                mem_must_wait = 1'b0;
            end
            if (mem_we) begin
                wr_addrs.push_back(mem_wr_addr);
                wr_datas.push_back(mem_wr_data);
                wr_bytes.push_back(mem_wr_bytes);
            end
            @(negedge clk);
        end
        mem_must_wait = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: re=%b we=%b rv=%b expected 0", mem_re, mem_we,
                               resp_valid);
        end
        req_valid = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        checks++; if (resp_fault !== 1'b0) begin
            errors++; $display("FAIL reset_fault: got %b expected 0", resp_fault);
        end
        checks++; if (resp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata);
        end
        checks++; if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
        end
    endtask

    task automatic test_aligned();
        mem[12'h100] = 8'hBB; mem[12'h101] = 8'hAA; mem[12'h102] = 8'h99; mem[12'h103] = 8'h88;
        run_req(1'b0, 32'h100, 3'd2, 1'b0, 32'h0, 0);
        checks++; if (resp_cyc !== 3) begin
            errors++; $display("FAIL aligned_load_latency: got %0d expected 3", resp_cyc);
        end
        checks++; if (resp_data !== 32'h8899AABB || resp_flt !== 1'b0) begin
            errors++; $display("FAIL aligned_load_data: got %h/%b expected 8899aabb/0",
                               resp_data, resp_flt);
        end
        checks++; if (rd_addrs.size() !== 1 || rd_addrs[0] !== 32'h100 || rd_bytes[0] !== 3'd2)
        begin
            errors++; $display("FAIL aligned_load_reads: got n=%0d addr=%h bytes=%0d expected 1/100/2",
                               rd_addrs.size(), rd_addrs[0], rd_bytes[0]);
        end
        run_req(1'b1, 32'h300, 3'd2, 1'b0, 32'hCAFEF00D, 0);
        checks++; if (resp_cyc !== 2) begin
            errors++; $display("FAIL aligned_store_latency: got %0d expected 2", resp_cyc);
        end
        checks++; if (wr_addrs.size() !== 1 || wr_addrs[0] !== 32'h300 ||
                      wr_datas[0] !== 32'hCAFEF00D || wr_bytes[0] !== 3'd2) begin
            errors++; $display("FAIL aligned_store_write: got n=%0d %h:%h/%0d expected 1 300:cafef00d/2",
                               wr_addrs.size(), wr_addrs[0], wr_datas[0], wr_bytes[0]);
        end
    endtask

    task automatic test_split_load();
        mem[12'h103] = 8'hF0; mem[12'h104] = 8'h80;
        run_req(1'b0, 32'h103, 3'd1, 1'b0, 32'h0, 0);
        checks++; if (resp_cyc !== 5) begin
            errors++; $display("FAIL split_load_latency: got %0d expected 5", resp_cyc);
        end
        checks++; if (resp_data !== 32'hFFFF80F0) begin
            errors++; $display("FAIL split_load_signed: got %h expected ffff80f0", resp_data);
        end
        checks++; if (rd_addrs.size() !== 2 || rd_addrs[0] !== 32'h103 || rd_addrs[1] !== 32'h104
                      || rd_bytes[0] !== 3'd0 || rd_bytes[1] !== 3'd0) begin
            errors++; $display("FAIL split_load_reads: got n=%0d %h %h expected 2 byte reads 103 104",
                               rd_addrs.size(), rd_addrs[0], rd_addrs[1]);
        end
        run_req(1'b0, 32'h103, 3'd1, 1'b1, 32'h0, 0);
        checks++; if (resp_data !== 32'h000080F0 || resp_cyc !== 5) begin
            errors++; $display("FAIL split_load_unsigned: got %h@%0d expected 000080f0@5",
                               resp_data, resp_cyc);
        end
    endtask

    task automatic test_split_store();
        logic [31:0] exp_data;
        run_req(1'b1, 32'h101, 3'd2, 1'b0, 32'h11223344, 0);
        checks++; if (resp_cyc !== 5 || resp_data !== 32'h0 || resp_flt !== 1'b0) begin
            errors++; $display("FAIL split_store_resp: got cyc=%0d rdata=%h fault=%b expected 5/0/0",
                               resp_cyc, resp_data, resp_flt);
        end
        checks++; if (wr_addrs.size() !== 4 || re_all.size() !== 0) begin
            errors++; $display("FAIL split_store_count: got writes=%0d reads=%0d expected 4/0",
                               wr_addrs.size(), re_all.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp_data = 32'h11223344 >> (8 * i);
            checks++; if (wr_addrs[i] !== 32'h101 + 32'(i) || wr_datas[i] !== exp_data ||
                          wr_bytes[i] !== 3'd0) begin
                errors++; $display("FAIL split_store_byte%0d: got %h:%h/%0d expected %h:%h/0", i,
                                   wr_addrs[i], wr_datas[i], wr_bytes[i], 32'h101 + 32'(i),
                                   exp_data);
            end
        end
    endtask

    task automatic test_must_wait();
        mem[12'h200] = 8'h5A;
        run_req(1'b0, 32'h200, 3'd0, 1'b0, 32'h0, 2);
        checks++; if (resp_cyc !== 5 || resp_data !== 32'h0000005A) begin
            errors++; $display("FAIL must_wait_resp: got %h@%0d expected 0000005a@5",
                               resp_data, resp_cyc);
        end
        checks++; if (re_all.size() !== 3 || re_all[0] !== 32'h200 || re_all[1] !== 32'h200 ||
                      re_all[2] !== 32'h200) begin
            errors++; $display("FAIL must_wait_hold: got re cycles=%0d addrs %h %h %h expected 3x200",
                               re_all.size(), re_all[0], re_all[1], re_all[2]);
        end
    endtask

    task automatic test_faults();
        // Bad size: 8B on a 32-bit port faults in both instances
        run_req(1'b0, 32'h100, 3'd3, 1'b0, 32'h0, 0);
        checks++; if (resp_cyc !== 1 || resp_flt !== 1'b1 || resp_data !== 32'h0) begin
            errors++; $display("FAIL bad_size: got cyc=%0d fault=%b rdata=%h expected 1/1/0",
                               resp_cyc, resp_flt, resp_data);
        end
        checks++; if (re_all.size() !== 0 || wr_addrs.size() !== 0) begin
            errors++; $display("FAIL bad_size_strobes: got re=%0d we=%0d expected 0/0",
                               re_all.size(), wr_addrs.size());
        end
        // Misaligned word: split in main instance, faulted in the strict one
        mem[12'h102] = 8'h01; mem[12'h103] = 8'h02; mem[12'h104] = 8'h03; mem[12'h105] = 8'h84;
        run_req(1'b0, 32'h102, 3'd2, 1'b0, 32'h0, 0);
        checks++; if (f_resp_cyc !== 1 || f_resp_flt !== 1'b1 || f_strobes !== 0) begin
            errors++; $display("FAIL misaligned_fault: got cyc=%0d fault=%b strobes=%0d expected 1/1/0",
                               f_resp_cyc, f_resp_flt, f_strobes);
        end
        checks++; if (resp_cyc !== 9 || resp_data !== 32'h84030201 || resp_flt !== 1'b0) begin
            errors++; $display("FAIL misaligned_split_word: got %h@%0d fault=%b expected 84030201@9/0",
                               resp_data, resp_cyc, resp_flt);
        end
        // 2B at all-ones wraps to address 0
        mem[12'hFFF] = 8'h34; mem[12'h000] = 8'h12;
        run_req(1'b0, 32'hFFFFFFFF, 3'd1, 1'b1, 32'h0, 0);
        checks++; if (rd_addrs.size() !== 2 || rd_addrs[0] !== 32'hFFFFFFFF ||
                      rd_addrs[1] !== 32'h0 || resp_data !== 32'h00001234) begin
            errors++; $display("FAIL addr_wrap: got n=%0d %h %h rdata=%h expected ffffffff 0 00001234",
                               rd_addrs.size(), rd_addrs[0], rd_addrs[1], resp_data);
        end
    endtask

    task automatic test_clr_midop();
        int seen;
        // Split load, clear during RDWAIT of the first byte
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h103; req_size = 3'd1; req_unsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL clr_rdwait_strobes: re=%b we=%b rv=%b expected 0", mem_re,
                               mem_we, resp_valid);
        end
        @(negedge clk);
        clr = 1'b0;
        checks++; if (req_ready !== 1'b1) begin
            errors++; $display("FAIL clr_ready: got %b expected 1", req_ready);
        end
        // Split store, clear while a byte write is being issued
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h101; req_size = 3'd2;
        req_wdata = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin
            errors++; $display("FAIL clr_issue_we: got %b expected 0", mem_we);
        end
        @(negedge clk);
        clr = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid || mem_re || mem_we) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL clr_abandon: got activity=%0d ready=%b expected 0/1", seen,
                               req_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        test_reset();
        test_aligned();
        test_split_load();
        test_split_store();
        test_must_wait();
        test_faults();
        test_clr_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
